// File: rtl/seq_detect_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_sched_if
//  Purpose  : Request/response bundle between N word-parallel requesters
//             (plus one response consumer) and the seq_detect_sched
//             round-robin scheduler.
//  Signals  : req_valid [N]        per-requester word valid
//             req_data  [N*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//             req_ready [N]        one-hot accept strobe (accept cycle only)
//             rsp_valid            response valid
//             rsp_id    [IDW]      requester id of the response
//             rsp_count [CW]       detector hit count for the word
//             rsp_ready            response consumer ready
//  Modports : master - requester/consumer side, slave - scheduler side
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_sched_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N),
    parameter int CW    = $clog2(WIDTH + 2)
);
    logic [N-1:0]       req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [CW-1:0]      rsp_count;
    logic               rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_sched.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_sched
//  Purpose  : Round-robin scheduler sharing one bit-serial sequence-detector
//             engine between N word-parallel requesters. Each accepted word
//             is preceded by a one-cycle detector flush, shifted out MSB
//             first, followed by one drain cycle; the number of cycles the
//             detector reported a hit is returned tagged with the requester id.
//  Ports    : clk        clock, rising edge
//             reset      synchronous, active-low
//             bus        seq_detect_sched_if.slave (request/response channels)
//             det_bit    serial bit to detector input
//             det_rst_n  detector synchronous active-low reset
//             det_seen   detector hit flag (from its state register)
//             busy       high in any state except IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_sched #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N),
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  wire                 clk,
    input  wire                 reset,
    seq_detect_sched_if.slave   bus,
    output logic                det_bit,
    output logic                det_rst_n,
    input  wire                 det_seen,
    output logic                busy
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q,   ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q,   idx_d;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;

    // (a + k) mod N for a < N, k < N
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IDW'(s);
    endfunction

    // Round-robin pick: first valid requester starting at ptr_q.
    always_comb begin
        logic [IDW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = wrap_add(ptr_q, k);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        word_d        = word_q;
        count_d       = count_q;
        idx_d         = idx_q;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_id    = '0;
        bus.rsp_count = '0;
        det_bit       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by reset so no accept strobe is seen while held in reset.
                if (reset && pick_found) begin
                    bus.req_ready[pick_idx] = 1'b1;
                    grant_d = pick_idx;
                    word_d  = bus.req_data[pick_idx*WIDTH +: WIDTH];
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                count_d = '0;
                idx_d   = IW'(WIDTH - 1);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                det_bit = word_q[idx_q];
                count_d = count_q + CW'(det_seen);
                if (idx_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DRAIN: begin
                // Detector output lags the input by one cycle: this picks up
                // the hit produced by the last shifted bit.
                count_d = count_q + CW'(det_seen);
                state_d = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = grant_q;
                bus.rsp_count = count_q;
                if (bus.rsp_ready) begin
                    ptr_d   = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign det_rst_n = reset && (state_q != S_FLUSH);
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            word_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            word_q  <= word_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

endmodule
`default_nettype wire
